// File: rtl/link_receiver_if.sv
// Link receiver bus: the arbiter stream in, the decoded payload and status out.
// dbg_state mirrors the receiver's FSM state for checkers.
interface link_receiver_if;
    logic [15:0] din;
    logic        kchar;
    logic [15:0] dout;
    logic [3:0]  chan;
    logic        dvalid;
    logic        sob;
    logic        eob;
    logic        trig;
    logic        err;
    logic [15:0] err_cnt;
    logic        busy;
    logic [1:0]  dbg_state;

    // The stream has no backpressure: the receiver consumes one word per clk
    // and flags a payload word with dvalid in the cycle after it was sampled.
    modport master (
        output din, kchar,
        input  dout, chan, dvalid, sob, eob, trig, err, err_cnt, busy, dbg_state
    );

    modport slave (
        input  din, kchar,
        output dout, chan, dvalid, sob, eob, trig, err, err_cnt, busy, dbg_state
    );
endinterface

// File: rtl/link_receiver.sv
// Link receiver: hunts for IDLE, parses SOB/header/payload blocks from a 16-bit
// K-coded stream, flags triggers and protocol errors. All outputs are registered.
module link_receiver #(
    parameter int MAX_LEN = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    link_receiver_if.slave   lnk
);
    localparam logic [15:0] K_IDLE    = 16'h50BC;
    localparam logic [15:0] K_SOB     = 16'h1CBC;
    localparam logic [15:0] K_TRIG    = 16'h7CBC;
    localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);

    typedef enum logic [1:0] {S_HUNT, S_IDLE, S_HDR, S_DATA} state_t;

    state_t      r_state, w_next;
    logic [11:0] r_rem, w_rem;
    logic        r_first, w_first;
    logic [15:0] r_dout, w_dout;
    logic [3:0]  r_chan, w_chan;
    logic        r_dvalid, w_dvalid;
    logic        r_sob, w_sob;
    logic        r_eob, w_eob;
    logic        r_trig, w_trig;
    logic        r_err, w_err;
    logic [15:0] r_err_cnt;
    logic        r_busy;

    logic        w_is_idle, w_is_sob, w_is_illegal, w_is_data, w_len_ok;
    logic [11:0] w_len;

    assign w_is_idle    = lnk.kchar && (lnk.din == K_IDLE);
    assign w_is_sob     = lnk.kchar && (lnk.din == K_SOB);
    assign w_trig       = lnk.kchar && (lnk.din == K_TRIG);
    assign w_is_illegal = lnk.kchar && !w_is_idle && !w_is_sob && !w_trig;
    assign w_is_data    = !lnk.kchar;
    assign w_len        = lnk.din[11:0];
    assign w_len_ok     = (w_len != 12'd0) && ({20'd0, w_len} <= MAX_LEN_U);

    // TRIG never reaches the case below as a state-changing word: it matches
    // none of the idle/sob/illegal/data branches.
    always_comb begin
        w_next   = r_state;
        w_rem    = r_rem;
        w_first  = r_first;
        w_dout   = r_dout;
        w_chan   = r_chan;
        w_dvalid = 1'b0;
        w_sob    = 1'b0;
        w_eob    = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_is_idle) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (w_is_sob)                       w_next = S_HDR;
                else if (w_is_data || w_is_illegal) w_err  = 1'b1;
            end
            S_HDR: begin
                if (w_is_data) begin
                    if (w_len_ok) begin
                        w_chan  = lnk.din[15:12];
                        w_rem   = w_len;
                        w_first = 1'b1;
                        w_next  = S_DATA;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (w_is_idle || w_is_illegal) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_is_sob) begin
                    w_err  = 1'b1;
                end
            end
            S_DATA: begin
                if (w_is_data) begin
                    w_dout   = lnk.din;
                    w_dvalid = 1'b1;
                    w_sob    = r_first;
                    w_first  = 1'b0;
                    w_rem    = r_rem - 12'd1;
                    if (r_rem == 12'd1) begin
                        w_eob  = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (w_is_sob || w_is_illegal) begin
                    // Abort: close the block without a payload word.
                    w_eob  = 1'b1;
                    w_err  = 1'b1;
                    w_next = w_is_sob ? S_HDR : S_IDLE;
                end
            end
            default: w_next = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_HUNT;
            r_rem     <= 12'd0;
            r_first   <= 1'b0;
            r_dout    <= 16'd0;
            r_chan    <= 4'd0;
            r_dvalid  <= 1'b0;
            r_sob     <= 1'b0;
            r_eob     <= 1'b0;
            r_trig    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 16'd0;
            r_busy    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rem    <= w_rem;
            r_first  <= w_first;
            r_dout   <= w_dout;
            r_chan   <= w_chan;
            r_dvalid <= w_dvalid;
            r_sob    <= w_sob;
            r_eob    <= w_eob;
            r_trig   <= w_trig;
            r_err    <= w_err;
            r_busy   <= (w_next == S_HDR) || (w_next == S_DATA);
            if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign lnk.dout      = r_dout;
    assign lnk.chan      = r_chan;
    assign lnk.dvalid    = r_dvalid;
    assign lnk.sob       = r_sob;
    assign lnk.eob       = r_eob;
    assign lnk.trig      = r_trig;
    assign lnk.err       = r_err;
    assign lnk.err_cnt   = r_err_cnt;
    assign lnk.busy      = r_busy;
    assign lnk.dbg_state = r_state;
endmodule
